alu_seq: RTL

Sequential, parametrised successor to the combinational ALU. It accepts one operation per handshake on a valid/ready input channel. Results and flags come back on a registered valid/ready output channel. Single-cycle ops complete in 1 cycle; MUL is an iterative shift-add multiply taking DATA_W cycles. It sits between the register-file read stage and writeback of the lecture CPU datapath.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_mul_seq.sv | 62 ++++++
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, defaults and FSM encodings for the sequential ALU.
// ALU_MUL_EN adds the MUL state and opcode 8 execution.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SEL_W_DEF  = 4;

  localparam int OP_THA = 0;
  localparam int OP_THB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_ADD = 4;
  localparam int OP_SUB = 5;
  localparam int OP_SL  = 6;
  localparam int OP_SR  = 7;
  localparam int OP_MUL = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    ST_MUL  = 2'd1,
`endif
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Built only when ALU_MUL_EN is defined.
module alu_mul_seq #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*DATA_W-1:0]   p_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     mcand_q, mcand_d;
  logic                  done_q, done_d;
  logic [DATA_W:0]       sum;

  // Low half starts as the multiplier and is consumed as the
  // partial product shifts in from the top.
  always_comb begin
    sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
        + (acc_q[0] ? {1'b0, mcand_q} : '0);
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    done_d  = 1'b0;
    if (start_i) begin
      cnt_d   = CNT_W'(DATA_W);
      acc_d   = {{DATA_W{1'b0}}, b_i};
      mcand_d = a_i;
    end else if (cnt_q != '0) begin
      acc_d  = {sum, acc_q[DATA_W-1:1]};
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = done_q;
  assign p_o    = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready in and registered valid/ready out.
// Define ALU_MUL_EN to build the iterative MUL path (opcode 8).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] y_hi,
  output logic              cf,
  output logic              zf
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] y_q, y_d;
  logic              cf_q, cf_d;
  logic              zf_q, zf_d;

  logic [DATA_W-1:0] res_y;
  logic              res_cf;
  logic [DATA_W:0]   add_w;
  logic [DATA_W:0]   sub_w;
  logic              accept;

  logic op_tha, op_thb, op_and, op_or;
  logic op_add, op_sub, op_sl, op_sr;

  assign op_tha = (s == SEL_W'(OP_THA));
  assign op_thb = (s == SEL_W'(OP_THB));
  assign op_and = (s == SEL_W'(OP_AND));
  assign op_or  = (s == SEL_W'(OP_OR));
  assign op_add = (s == SEL_W'(OP_ADD));
  assign op_sub = (s == SEL_W'(OP_SUB));
  assign op_sl  = (s == SEL_W'(OP_SL));
  assign op_sr  = (s == SEL_W'(OP_SR));

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  // Undefined opcodes (and MUL here) fall to y=0, cf=0.
  always_comb begin
    res_y  = '0;
    res_cf = 1'b0;
    unique case (1'b1)
      op_tha: res_y = a;
      op_thb: res_y = b;
      op_and: res_y = a & b;
      op_or:  res_y = a | b;
      op_add: {res_cf, res_y} = add_w;
      op_sub: {res_cf, res_y} = sub_w;
      op_sl: begin
        res_y  = {a[DATA_W-2:0], 1'b0};
        res_cf = a[DATA_W-1];
      end
      op_sr: begin
        res_y  = {1'b0, a[DATA_W-1:1]};
        res_cf = a[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                  is_mul;
  logic                  mul_start;
  logic                  mul_busy;
  logic                  mul_done;
  logic [2*DATA_W-1:0]   mul_p;
  logic [DATA_W-1:0]     y_hi_q, y_hi_d;

  assign is_mul = (s == SEL_W'(OP_MUL));

  alu_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  assign in_ready = ~mul_busy
                  & ((state_q == ST_IDLE)
                  | ((state_q == ST_DONE) & out_ready));
  assign y_hi = y_hi_q;
`else
  assign in_ready = (state_q == ST_IDLE)
                  | ((state_q == ST_DONE) & out_ready);
  assign y_hi = '0;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
`ifdef ALU_MUL_EN
    y_hi_d    = y_hi_q;
    mul_start = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: ;
      ST_DONE: begin
        if (out_ready && !in_valid) state_d = ST_IDLE;
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_DONE;
          y_d     = mul_p[DATA_W-1:0];
          y_hi_d  = mul_p[2*DATA_W-1:DATA_W];
          cf_d    = (mul_p[2*DATA_W-1:DATA_W] != '0);
          zf_d    = (mul_p[DATA_W-1:0] == '0);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // A new op in DONE transfers the old result on the same edge.
    if (accept) begin
`ifdef ALU_MUL_EN
      if (is_mul) begin
        state_d   = ST_MUL;
        mul_start = 1'b1;
      end else begin
        state_d = ST_DONE;
        y_d     = res_y;
        y_hi_d  = '0;
        cf_d    = res_cf;
        zf_d    = (res_y == '0);
      end
`else
      state_d = ST_DONE;
      y_d     = res_y;
      cf_d    = res_cf;
      zf_d    = (res_y == '0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
`ifdef ALU_MUL_EN
      y_hi_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
`ifdef ALU_MUL_EN
      y_hi_q  <= y_hi_d;
`endif
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;
  assign cf        = cf_q;
  assign zf        = zf_q;

endmodule
